// File: rtl/counter.sv
// Ripple down counter: a chain of toggle flip-flops where each stage above
// stage 0 is clocked by the rising edge of the stage below it.

module counter_tff (
  input  logic clk,
  input  logic rst_n,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (t_i) begin
      q_d = ~q_q;
    end
  end

  // NOTE: non-blocking assignment keeps the update ordered after every reader of this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

module counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             t_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic stage_clk;

    if (i == 0) begin : g_first
      assign stage_clk = clk;
    end else begin : g_ripple
      // A 0->1 step on the lower bit is a borrow into this bit, so the
      // chain counts down. Reset only drives bits low and cannot fake an edge.
      assign stage_clk = stage_q[i-1];
    end

    counter_tff u_tff (
      .clk   (stage_clk),
      .rst_n (rst_n),
      .t_i   (t_i),
      .q_o   (stage_q[i])
    );
  end

  assign q_o = stage_q;

endmodule

// File: tb/tb_counter.sv
// Bench for the ripple down counter: directed scenarios plus random T and
// reset pulses, all compared against a modulo-2^WIDTH decrement model.

module tb_counter;

  localparam int WIDTH = 3;
  localparam int MOD   = 1 << WIDTH;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             t_i   = 1'b0;
  logic [WIDTH-1:0] q_o;

  int checks = 0;
  int errors = 0;
  int model  = 0;

  counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .t_i   (t_i),
    .q_o   (q_o)
  );

  always #10 clk = ~clk;

  // One rising edge: the model decrements when counting is enabled and reset is
  // released; outputs are sampled 1 ns later, well after the ripple has settled.
  task automatic step();
    @(posedge clk);
    if (rst_n && t_i) model = (model + MOD - 1) % MOD;
    #1;
  endtask

  // Runs counting edges until the model reaches target; bounded.
  task automatic run_to(input int target, input string name);
    int n = 0;
    t_i = 1'b1;
    while (model != target && n < 2 * MOD) begin
      step();
      n++;
    end
    checks++;
    if (q_o !== target[WIDTH-1:0]) begin
      errors++;
      $display("FAIL %s: q=%0d required %0d", name, q_o, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    t_i   = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (q_o !== '0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: q=%0d required 0", i, q_o);
      end
      #10;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    model = 0;
    #1;
    checks++;
    if (q_o !== '0) begin
      errors++;
      $display("FAIL reset_release: q=%0d required 0", q_o);
    end
  endtask

  task automatic test_count_down();
    t_i = 1'b1;
    for (int i = 0; i < MOD; i++) begin
      step();
      checks++;
      if (q_o !== WIDTH'(MOD - 1 - i)) begin
        errors++;
        $display("FAIL count_down[%0d]: q=%0d required %0d", i, q_o, MOD - 1 - i);
      end
    end
  endtask

  task automatic test_wrap();
    int prev;
    t_i = 1'b1;
    for (int i = 0; i < 4 * MOD; i++) begin
      prev = model;
      step();
      checks++;
      if (q_o !== model[WIDTH-1:0]) begin
        errors++;
        $display("FAIL wrap[%0d]: q=%0d required %0d", i, q_o, model);
      end
      if (prev == 0) begin
        checks++;
        if (q_o !== WIDTH'(MOD - 1)) begin
          errors++;
          $display("FAIL wrap_all_ones[%0d]: q=%0d required %0d", i, q_o, MOD - 1);
        end
      end
    end
  endtask

  task automatic test_hold();
    run_to(5, "hold_reach");
    t_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (q_o !== 3'd5) begin
        errors++;
        $display("FAIL hold[%0d]: q=%0d required 5", i, q_o);
      end
    end
    t_i = 1'b1;
    step();
    checks++;
    if (q_o !== 3'd4) begin
      errors++;
      $display("FAIL hold_resume: q=%0d required 4", q_o);
    end
  endtask

  task automatic test_mid_reset();
    run_to(3, "mid_reset_reach");
    #4;
    rst_n = 1'b0;
    model = 0;
    #1;
    checks++;
    if (q_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear: q=%0d required 0", q_o);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (q_o !== '0) begin
        errors++;
        $display("FAIL mid_reset_held[%0d]: q=%0d required 0", i, q_o);
      end
    end
    #4;
    rst_n = 1'b1;
    step();
    checks++;
    if (q_o !== WIDTH'(MOD - 1)) begin
      errors++;
      $display("FAIL mid_reset_first: q=%0d required %0d", q_o, MOD - 1);
    end
  endtask

  task automatic test_no_spurious();
    run_to(MOD - 1, "spurious_reach");
    #3;
    rst_n = 1'b0;
    model = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (q_o !== '0) begin
        errors++;
        $display("FAIL spurious_low[%0d]: q=%0d required 0", i, q_o);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (q_o !== '0) begin
      errors++;
      $display("FAIL spurious_release: q=%0d required 0", q_o);
    end
    step();
    checks++;
    if (q_o !== WIDTH'(MOD - 1)) begin
      errors++;
      $display("FAIL spurious_first: q=%0d required %0d", q_o, MOD - 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      t_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        #3;
        rst_n = 1'b0;
        model = 0;
        #2;
        checks++;
        if (q_o !== '0) begin
          errors++;
          $display("FAIL random_reset[%0d]: q=%0d required 0", i, q_o);
        end
        rst_n = 1'b1;
      end
      step();
      checks++;
      if (q_o !== model[WIDTH-1:0]) begin
        errors++;
        $display("FAIL random[%0d]: q=%0d required %0d t=%0b", i, q_o, model, t_i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_down();
    test_wrap();
    test_hold();
    test_mid_reset();
    test_no_spurious();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
